uart_rx_bcd: RTL and testbench

Serial receive front-end for the remote-calculator path. Deserialises 8N1 UART frames from the rxd pin and emits the received byte. Converts the byte to decimal digits with a sequential double-dabble and presents them as four BCD nibbles. These nibbles are the operand/result feed for the Calculator and DigitalLED stages.

---
 rtl/uart_rx_bcd.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_uart_rx_bcd.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_bcd.sv
// uart_rx_bcd -- UART receive front-end with binary-to-BCD conversion.
//
// Receives 8N1 frames on rxd using 16x oversampling. Each good byte is
// presented on data and split into decimal digits by a sequential
// double-dabble. The digits go out as four BCD nibbles. num1 is the
// thousands digit and is always 0 for an 8-bit value.
//
// Optional feature: define UART_RX_PARITY_EN to receive 8E1 frames. An even
// parity bit then follows bit 7, and a mismatch pulses parityError. Without
// the macro, parityError is tied low.
//
// Parameters:
//   clkFreq     system clock frequency in Hz
//   baudRate    serial bit rate; tick divisor = clkFreq/(baudRate*16), min 1
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   rxd          raw serial input, idle high, asynchronous to clk
//   data         last good received byte
//   dataReady    one-cycle pulse when data and num1..num4 update
//   num1..num4   thousands/hundreds/tens/units BCD digits
//   frameError   one-cycle pulse on a bad stop bit
//   parityError  one-cycle pulse on a parity mismatch (parity build only)
//   busy         high while the receiver is not in IDLE
module uart_rx_bcd #(
    parameter int clkFreq  = 50000000,
    parameter int baudRate = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       dataReady,
    output logic [3:0] num1,
    output logic [3:0] num2,
    output logic [3:0] num3,
    output logic [3:0] num4,
    output logic       frameError,
    output logic       parityError,
    output logic       busy
);

    localparam int DIV_RAW = clkFreq / (baudRate * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5,
        CONVERT   = 3'd6
    } state_t;

    // One double-dabble step on {bcd[11:0], bin[7:0]}: add 3 to each BCD
    // nibble that is 5 or more, then shift the whole register left by one.
    function automatic logic [19:0] dabble_step(input logic [19:0] v);
        logic [19:0] a;
        a = v;
        for (int n = 0; n < 3; n++) begin
            if (a[8+4*n +: 4] >= 4'd5) begin
                a[8+4*n +: 4] = a[8+4*n +: 4] + 4'd3;
            end else begin
                a[8+4*n +: 4] = a[8+4*n +: 4];
            end
        end
        return {a[18:0], 1'b0};
    endfunction

`ifdef UART_RX_PARITY_EN
    // Returns 1 when data plus the even-parity bit has odd weight.
    function automatic logic parity_bad(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction
`endif

    state_t           state_q, state_d;
    logic             rxd_s1_q, rxd_s2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       sub_q, sub_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [3:0]       conv_q, conv_d;
    logic [11:0]      bcd_q, bcd_d;
    logic [7:0]       bin_q, bin_d;
    logic [7:0]       data_q, data_d;
    logic [3:0]       num2_q, num2_d, num3_q, num3_d, num4_q, num4_d;
    logic             ready_q, ready_d;
    logic             ferr_q, ferr_d;
    logic             busy_q, busy_d;
    logic             tick_s;
    logic             rxd_s;
`ifdef UART_RX_PARITY_EN
    logic             par_q, par_d;
    logic             perr_q, perr_d;
`endif

    assign rxd_s  = rxd_s2_q;
    assign tick_s = (cnt_q == CNT_W'(DIV - 1));

    // Next-state, datapath and output-pulse decode.
    always_comb begin
        state_d = state_q;
        sub_d   = sub_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        conv_d  = conv_q;
        bcd_d   = bcd_q;
        bin_d   = bin_q;
        data_d  = data_q;
        num2_d  = num2_q;
        num3_d  = num3_q;
        num4_d  = num4_q;
        ready_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        // Free-running oversample divider, realigned to the start edge.
        if (tick_s) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            // Level detect: IDLE is only entered with the line high, so a low
            // level here is a fresh start edge, including one that arrived
            // while CONVERT was still running.
            IDLE: begin
                if (!rxd_s) begin
                    state_d = START;
                    sub_d   = 4'd0;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (tick_s && (sub_q == 4'd7)) begin
                    sub_d = 4'd0;
                    bit_d = 3'd0;
                    if (rxd_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                    end
                end else if (tick_s) begin
                    sub_d = sub_q + 4'd1;
                end else begin
                    sub_d = sub_q;
                end
            end
            DATA: begin
                if (tick_s && (sub_q == 4'd15)) begin
                    sub_d   = 4'd0;
                    shreg_d = {rxd_s, shreg_q[7:1]};
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else if (tick_s) begin
                    sub_d = sub_q + 4'd1;
                end else begin
                    sub_d = sub_q;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick_s && (sub_q == 4'd15)) begin
                    sub_d   = 4'd0;
                    par_d   = rxd_s;
                    state_d = STOP;
                end else if (tick_s) begin
                    sub_d = sub_q + 4'd1;
                end else begin
                    sub_d = sub_q;
                end
            end
`endif
            STOP: begin
                if (tick_s && (sub_q == 4'd15)) begin
                    sub_d = 4'd0;
                    if (!rxd_s) begin
                        // Framing error wins over a parity error.
                        ferr_d  = 1'b1;
                        state_d = WAIT_IDLE;
`ifdef UART_RX_PARITY_EN
                    end else if (parity_bad(shreg_q, par_q)) begin
                        perr_d  = 1'b1;
                        state_d = IDLE;
`endif
                    end else begin
                        bin_d   = shreg_q;
                        bcd_d   = 12'd0;
                        conv_d  = 4'd0;
                        state_d = CONVERT;
                    end
                end else if (tick_s) begin
                    sub_d = sub_q + 4'd1;
                end else begin
                    sub_d = sub_q;
                end
            end
            WAIT_IDLE: begin
                if (rxd_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_IDLE;
                end
            end
            // Eight shift cycles, then one cycle to publish the result.
            // shreg_q is untouched here, so it still holds the received byte.
            CONVERT: begin
                if (conv_q == 4'd8) begin
                    data_d  = shreg_q;
                    num2_d  = bcd_q[11:8];
                    num3_d  = bcd_q[7:4];
                    num4_d  = bcd_q[3:0];
                    ready_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    {bcd_d, bin_d} = dabble_step({bcd_q, bin_q});
                    conv_d = conv_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, synchroniser and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rxd_s1_q <= 1'b1;
            rxd_s2_q <= 1'b1;
            cnt_q    <= '0;
            sub_q    <= 4'd0;
            bit_q    <= 3'd0;
            shreg_q  <= 8'd0;
            conv_q   <= 4'd0;
            bcd_q    <= 12'd0;
            bin_q    <= 8'd0;
            data_q   <= 8'd0;
            num2_q   <= 4'd0;
            num3_q   <= 4'd0;
            num4_q   <= 4'd0;
            ready_q  <= 1'b0;
            ferr_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q    <= 1'b0;
            perr_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            rxd_s1_q <= rxd;
            rxd_s2_q <= rxd_s1_q;
            cnt_q    <= cnt_d;
            sub_q    <= sub_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            conv_q   <= conv_d;
            bcd_q    <= bcd_d;
            bin_q    <= bin_d;
            data_q   <= data_d;
            num2_q   <= num2_d;
            num3_q   <= num3_d;
            num4_q   <= num4_d;
            ready_q  <= ready_d;
            ferr_q   <= ferr_d;
            busy_q   <= busy_d;
`ifdef UART_RX_PARITY_EN
            par_q    <= par_d;
            perr_q   <= perr_d;
`endif
        end
    end

    assign data       = data_q;
    assign dataReady  = ready_q;
    assign num1       = 4'd0;
    assign num2       = num2_q;
    assign num3       = num3_q;
    assign num4       = num4_q;
    assign frameError = ferr_q;
    assign busy       = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parityError = perr_q;
`else
    assign parityError = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_bcd.sv
`timescale 1ns/1ps
module tb_uart_rx_bcd;

    localparam int BIT = 160;  // clk per bit: divisor 10 x 16 ticks
`ifdef UART_RX_PARITY_EN
    localparam int NB = 10;    // data bits + parity + stop after the start bit
`else
    localparam int NB = 9;
`endif
    // Start edge -> 2 sync flops -> 1 detect cycle -> 8 ticks to mid start
    // bit -> NB bit periods to the stop sample.
    localparam int STOP_LAT = 3 + 80 + BIT * NB;
    localparam int RDY_LAT  = STOP_LAT + 9;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rxd = 1'b1;
    logic [7:0] data;
    logic       dataReady, frameError, parityError, busy;
    logic [3:0] num1, num2, num3, num4;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_cnt = 0;
    int fe_cnt = 0;
    int pe_cnt = 0;
    int fe_cyc = 0;
    int rdy_cyc [8];
    logic [15:0] rdy_num [8];
    logic [7:0]  rdy_data [8];
    int last_start = 0;
`ifdef UART_RX_PARITY_EN
    bit bad_par = 1'b0;
`endif

    uart_rx_bcd #(.clkFreq(1600000), .baudRate(10000)) dut (
        .clk(clk), .reset(reset), .rxd(rxd), .data(data),
        .dataReady(dataReady), .num1(num1), .num2(num2), .num3(num3),
        .num4(num4), .frameError(frameError), .parityError(parityError),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (dataReady) begin
            if (rdy_cnt < 8) begin
                rdy_cyc[rdy_cnt]  = cyc;
                rdy_num[rdy_cnt]  = {num1, num2, num3, num4};
                rdy_data[rdy_cnt] = data;
            end
            rdy_cnt = rdy_cnt + 1;
        end
        if (frameError) begin
            fe_cnt = fe_cnt + 1;
            fe_cyc = cyc;
        end
        if (parityError) pe_cnt = pe_cnt + 1;
    end

    task automatic clear_mon();
        rdy_cnt = 0;
        fe_cnt = 0;
        pe_cnt = 0;
    endtask

    // Drives one frame; the stop level lasts stop_cycles clocks.
    task automatic send(input logic [7:0] b, input logic stop_v, input int stop_cycles);
        @(posedge clk);
        #1;
        last_start = cyc;
        rxd = 1'b0;
        repeat (BIT) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rxd = b[i];
            repeat (BIT) @(posedge clk);
        end
`ifdef UART_RX_PARITY_EN
        #1 rxd = (^b) ^ bad_par;
        repeat (BIT) @(posedge clk);
`endif
        #1 rxd = stop_v;
        repeat (stop_cycles - 1) @(posedge clk);
    endtask

    task automatic test_reset();
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if ({data, num1, num2, num3, num4, dataReady, frameError, parityError, busy} !== 28'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h/%h%h%h%h/%b%b%b%b required all zero",
                     data, num1, num2, num3, num4, dataReady, frameError, parityError, busy);
        end
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy: got %b required 0", busy);
        end
    endtask

    task automatic test_c8();
        int s;
        clear_mon();
        send(8'hC8, 1'b1, BIT);
        s = last_start;
        repeat (30) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rdy_cnt !== 1) begin
            errors++;
            $display("FAIL c8_ready_count: got %0d required 1", rdy_cnt);
        end
        checks++;
        if (rdy_cyc[0] !== s + RDY_LAT) begin
            errors++;
            $display("FAIL c8_latency: got cycle %0d required %0d", rdy_cyc[0], s + RDY_LAT);
        end
        checks++;
        if (rdy_data[0] !== 8'hC8 || data !== 8'hC8) begin
            errors++;
            $display("FAIL c8_data: got %h/%h required c8", rdy_data[0], data);
        end
        checks++;
        if (rdy_num[0] !== 16'h0200) begin
            errors++;
            $display("FAIL c8_digits: got %h required 0200", rdy_num[0]);
        end
        checks++;
        if (busy !== 1'b0 || fe_cnt !== 0) begin
            errors++;
            $display("FAIL c8_after: got busy %b frameErrors %0d required 0 0", busy, fe_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int s1;
        int s2;
        clear_mon();
        send(8'hFF, 1'b1, BIT);
        s1 = last_start;
        send(8'h07, 1'b1, BIT);
        s2 = last_start;
        repeat (30) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rdy_cnt !== 2) begin
            errors++;
            $display("FAIL b2b_ready_count: got %0d required 2", rdy_cnt);
        end
        checks++;
        if (rdy_num[0] !== 16'h0255 || rdy_data[0] !== 8'hFF) begin
            errors++;
            $display("FAIL b2b_first: got %h/%h required 0255/ff", rdy_num[0], rdy_data[0]);
        end
        checks++;
        if (rdy_num[1] !== 16'h0007 || rdy_data[1] !== 8'h07) begin
            errors++;
            $display("FAIL b2b_second: got %h/%h required 0007/07", rdy_num[1], rdy_data[1]);
        end
        checks++;
        if (rdy_cyc[0] !== s1 + RDY_LAT || rdy_cyc[1] !== s2 + RDY_LAT) begin
            errors++;
            $display("FAIL b2b_latency: got %0d,%0d required %0d,%0d",
                     rdy_cyc[0], rdy_cyc[1], s1 + RDY_LAT, s2 + RDY_LAT);
        end
    endtask

    task automatic test_glitch();
        clear_mon();
        @(posedge clk);
        #1 rxd = 1'b0;
        repeat (40) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (200) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rdy_cnt !== 0 || fe_cnt !== 0) begin
            errors++;
            $display("FAIL glitch_pulses: got ready %0d frameErrors %0d required 0 0", rdy_cnt, fe_cnt);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_idle: got busy %b required 0", busy);
        end
        checks++;
        if ({num1, num2, num3, num4} !== 16'h0007 || data !== 8'h07) begin
            errors++;
            $display("FAIL glitch_hold: got %h/%h required 0007/07", {num1, num2, num3, num4}, data);
        end
    endtask

    task automatic test_midframe_reset();
        logic [7:0] b;
        b = 8'hFF;
        clear_mon();
        @(posedge clk);
        #1 rxd = 1'b0;
        repeat (BIT) @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            #1 rxd = b[i];
            repeat ((i == 4) ? BIT / 2 : BIT) @(posedge clk);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({data, num1, num2, num3, num4, dataReady, frameError, parityError, busy} !== 28'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got %h/%h%h%h%h/%b%b%b%b required all zero",
                     data, num1, num2, num3, num4, dataReady, frameError, parityError, busy);
        end
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        rxd = 1'b1;
        repeat (2 * BIT) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rdy_cnt !== 0 || fe_cnt !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_quiet: got ready %0d frameErrors %0d busy %b required 0 0 0",
                     rdy_cnt, fe_cnt, busy);
        end
        send(8'h63, 1'b1, BIT);
        repeat (30) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rdy_cnt !== 1 || rdy_num[0] !== 16'h0099 || data !== 8'h63) begin
            errors++;
            $display("FAIL midreset_next: got count %0d digits %h data %h required 1 0099 63",
                     rdy_cnt, rdy_num[0], data);
        end
    endtask

    task automatic test_frame_error();
        int s;
        clear_mon();
        send(8'h2A, 1'b0, 2 * BIT);
        s = last_start;
        #1 rxd = 1'b1;
        repeat (200) @(posedge clk);
        @(negedge clk);
        checks++;
        if (fe_cnt !== 1 || fe_cyc !== s + STOP_LAT) begin
            errors++;
            $display("FAIL ferr_pulse: got count %0d at %0d required 1 at %0d", fe_cnt, fe_cyc, s + STOP_LAT);
        end
        checks++;
        if (rdy_cnt !== 0 || pe_cnt !== 0) begin
            errors++;
            $display("FAIL ferr_no_ready: got ready %0d parityErrors %0d required 0 0", rdy_cnt, pe_cnt);
        end
        checks++;
        if ({num1, num2, num3, num4} !== 16'h0099 || data !== 8'h63) begin
            errors++;
            $display("FAIL ferr_hold: got %h/%h required 0099/63", {num1, num2, num3, num4}, data);
        end
        clear_mon();
        send(8'h00, 1'b1, BIT);
        repeat (30) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rdy_cnt !== 1 || rdy_num[0] !== 16'h0000 || data !== 8'h00) begin
            errors++;
            $display("FAIL ferr_recover: got count %0d digits %h data %h required 1 0000 00",
                     rdy_cnt, rdy_num[0], data);
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        clear_mon();
        bad_par = 1'b1;
        send(8'h03, 1'b1, BIT);
        bad_par = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        checks++;
        if (pe_cnt !== 1 || rdy_cnt !== 0 || fe_cnt !== 0) begin
            errors++;
            $display("FAIL parity_bad: got parityErrors %0d ready %0d frameErrors %0d required 1 0 0",
                     pe_cnt, rdy_cnt, fe_cnt);
        end
        checks++;
        if (data !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL parity_hold: got data %h busy %b required 00 0", data, busy);
        end
        clear_mon();
        send(8'h03, 1'b1, BIT);
        repeat (30) @(posedge clk);
        @(negedge clk);
        checks++;
        if (pe_cnt !== 0 || rdy_cnt !== 1 || rdy_num[0] !== 16'h0003) begin
            errors++;
            $display("FAIL parity_good: got parityErrors %0d ready %0d digits %h required 0 1 0003",
                     pe_cnt, rdy_cnt, rdy_num[0]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_c8();
        test_back_to_back();
        test_glitch();
        test_midframe_reset();
        test_frame_error();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
